// File: rtl/ds_spill_ctrl.sv
// rtl/ds_spill_ctrl.sv - spill/fill controller below the data_stack bottom cell
//
// Purpose:
//   Extends data_stack into a memory spill region. A push onto a full on-chip
//   stack writes the word leaving sr127 to memory. A pop while spilled words
//   exist feeds sr127 from a cached top-of-spill register (top_q), which is
//   then refilled from memory. stall is high while a memory access is open.
//
// Ports:
//   clk, async_reset           clock, asynchronous active-high reset
//   push, pop                  stack command strobes (shared with data_stack)
//   data_write, data_read      data_stack write/read qualifiers
//   ds_size[15:0]              on-chip occupancy
//   sr127_out[15:0]            bottom-cell value before the shift
//   sr127_in[15:0]             value shifted into sr127 on a pop
//   stall                      memory transaction in flight
//   mem_req, mem_we            request (held until mem_ready), 1 = write
//   mem_addr[15:0]             word address
//   mem_wdata[15:0]            spill data
//   mem_rdata[15:0]            fill data, valid with mem_ready
//   mem_ready                  request accepted/completed
//   spill_count[15:0]          words held in memory
//   spill_overflow             sticky: spill attempted with region full
//   cmd_dropped                sticky: command arrived during stall

module ds_spill_ctrl #(
  parameter logic [15:0] SPILL_BASE  = 16'h0000,
  parameter int unsigned SPILL_DEPTH = 1024,
  parameter int unsigned FULL_LEVEL  = 128
) (
  input  logic        clk,
  input  logic        async_reset,
  input  logic        push,
  input  logic        pop,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [15:0] ds_size,
  input  logic [15:0] sr127_out,
  output logic [15:0] sr127_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] spill_count,
  output logic        spill_overflow,
  output logic        cmd_dropped
);

  localparam logic [15:0] DEPTH16 = 16'(SPILL_DEPTH);
  localparam logic [15:0] FULL16  = 16'(FULL_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] top_q, top_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        drop_q, drop_d;

  logic        psh;
  logic        pp;
  logic        at_full;
  logic [15:0] new_count;

  // Simultaneous push and pop is a no-op for this block.
  assign psh     = push & data_write & ~pop;
  assign pp      = pop & data_read & ~push;
  assign at_full = (ds_size >= FULL16);

  // State register
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= ST_IDLE;
      top_q   <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      count_q <= 16'h0000;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    new_count = count_q - 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (psh && at_full) begin
          if (count_q < DEPTH16) begin
            // The pre-shift bottom word becomes the new top of spill, so the
            // cache is already correct and no read-back is needed later.
            wdata_d = sr127_out;
            addr_d  = SPILL_BASE + count_q;
            top_d   = sr127_out;
            count_d = count_q + 16'd1;
            state_d = ST_SPILL;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (pp && (count_q != 16'h0000)) begin
          // data_stack takes top_q on this edge; fetch the next one down.
          count_d = new_count;
          if (new_count != 16'h0000) begin
            addr_d  = SPILL_BASE + new_count - 16'd1;
            state_d = ST_FILL;
          end else begin
            top_d = 16'h0000;
          end
        end
      end

      ST_SPILL: begin
        if (psh || pp) drop_d = 1'b1;
        if (mem_ready) state_d = ST_IDLE;
      end

      ST_FILL: begin
        if (psh || pp) drop_d = 1'b1;
        if (mem_ready) begin
          top_d   = mem_rdata;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: decoded from registered state only, so mem_ready never reaches
  // stall combinationally and reset clears mem_req immediately.
  always_comb begin
    stall          = (state_q != ST_IDLE);
    mem_req        = (state_q != ST_IDLE);
    mem_we         = (state_q == ST_SPILL);
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    sr127_in       = top_q;
    spill_count    = count_q;
    spill_overflow = ovf_q;
    cmd_dropped    = drop_q;
  end

endmodule
